// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: FETCH/DECODE/execute/writeback sequencing plus datapath controls.
// Optional macro MC_ILLEGAL_TRAP_EN sends undefined opcodes to a sticky TRAP state flagged by illegal_op.
module mc_main_ctrl #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_LAT       = 0,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic [3:0]       state,
    output logic             instr_done,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic             illegal_op,
`endif
    output logic [CNT_W-1:0] retired
);
    localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                           S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                           S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,  S_BRANCH = 4'd8,
                           S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP   = 4'd12;
`endif
    localparam logic [5:0] OP_LW   = 6'b100011, OP_SW  = 6'b101011, OP_R = 6'b000000,
                           OP_BEQ  = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam int              WW  = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [WW-1:0]   LAT = WW'(MEM_LAT);

    logic [3:0]       state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] retired_q;
    logic             mem_st, mem_done;

    // rst_n gates mem_done so FETCH does not load IR/PC while reset is held.
    assign mem_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_done = mem_st && rst_n &&
                      ((MEM_HANDSHAKE != 0) ? mem_ready : (wait_q == LAT));
    assign wait_d   = (mem_st && !mem_done) ? wait_q + 1'b1 : '0;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_done ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_done ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite  = 1'b0; iord     = 1'b0; memread  = 1'b0; memwrite = 1'b0;
        irwrite  = 1'b0; regdst   = 1'b0; memtoreg = 1'b0; regwrite = 1'b0;
        alusrca  = 1'b0; alusrcb  = 2'b00; aluop   = 2'b00; pcsrc    = 2'b00;
        case (state_q)
            S_FETCH:  begin memread = 1'b1; alusrcb = 2'b01; irwrite = mem_done; pcwrite = mem_done; end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_MEMRD:  begin iord = 1'b1; memread = 1'b1; end
            S_MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; end
            S_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
            S_EXEC:   begin alusrca = 1'b1; aluop = 2'b10; end
            S_ALUWB:  begin regdst = 1'b1; regwrite = 1'b1; end
            S_BRANCH: begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; pcwrite = zero; end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP:   begin pcsrc = 2'b10; pcwrite = 1'b1; end
            default:  ;
        endcase
    end

    assign instr_done = (state_d == S_FETCH) && (state_q != S_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_q + CNT_W'(instr_done);
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  illegal_q <= 1'b0;
        else if (state_d == S_TRAP)  illegal_q <= 1'b1;
    end
    assign illegal_op = illegal_q;
`endif

    assign state   = state_q;
    assign retired = retired_q;
endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle successor to the single-cycle MIPS main decoder.
- Takes opcode bits [31:26] from the external instruction register, the ALU zero flag and a memory ready/latency indication.
- Sequences each instruction through FETCH/DECODE/execute/writeback states and drives the datapath controls each cycle.
- Sits between the IR and the shared-memory multicycle datapath; the existing ALU decoder consumes aluop unchanged.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory access completes on mem_ready; 0 = completes after a fixed MEM_LAT wait cycles (mem_ready ignored).
- MEM_LAT, 0, extra wait cycles per memory state when MEM_HANDSHAKE=0; 0 = single-cycle memory.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  6  opcode from IR; stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion strobe (MEM_HANDSHAKE=1 only).
- pcwrite  out  1  PC load enable (unconditional and branch-taken, already combined).
- iord  out  1  0 = memory address from PC; 1 = memory address from ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  IR load.
- regdst, memtoreg, regwrite  out  1 each  register-file controls, same meaning as the single-cycle decoder.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- aluop  out  2  00 add, 01 sub, 10 funct-decoded.
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state code, for debug.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
State codes:
- 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 ALUWB, 8 BRANCH, 9 ADDIEX, 10 ADDIWB, 11 JUMP, 12 TRAP. Codes 13–15 are unreachable; if entered, go to FETCH.

mem_done (memory states FETCH, MEMRD, MEMWR only):
- MEM_HANDSHAKE=1: mem_done = mem_ready.
- MEM_HANDSHAKE=0: mem_done = (wait_cnt == MEM_LAT).
- wait_cnt increments while in a memory state without mem_done. It clears on mem_done and on leaving the state.

Transitions:
- FETCH → DECODE on mem_done; otherwise hold.
- DECODE by op:
  - 100011 or 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other opcode → FETCH
- MEMADR → MEMRD (lw) or MEMWR (sw).
- MEMRD → MEMWB on mem_done; otherwise hold.
- MEMWR → FETCH on mem_done; otherwise hold.
- MEMWB, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
- EXEC → ALUWB; ADDIEX → ADDIWB.

Outputs (any output not listed is 0):
- FETCH: memread=1, alusrcb=01; irwrite = pcwrite = mem_done.
- DECODE: alusrcb=11.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10.
- MEMRD: iord=1, memread=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1, held for the whole state.
- EXEC: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, pcwrite=zero.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.

instr_done:
- High in any cycle whose next state is FETCH and whose current state is not FETCH.
- An undefined opcode in DECODE also pulses instr_done.
- retired increments on each instr_done and wraps from 2^CNT_W−1 to 0.

Reset:
- Asynchronous assertion forces FETCH, wait_cnt=0 and retired=0.
- Resulting output values: memread=1, alusrcb=01, irwrite=pcwrite=0 (mem_done is blocked during reset); all other outputs 0.
- Reset in the middle of MEMWR drops memwrite immediately.
- Release takes effect on the next clk edge.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in DECODE goes to TRAP instead of FETCH.
  - Adds output illegal_op (1 bit), set on entry to TRAP and held.
  - TRAP asserts no datapath controls and is left only by reset.
  - instr_done does not pulse and retired does not increment for the trapping instruction.
- Not defined: undefined opcodes retire as NOPs, as described above. Neither the illegal_op port nor the TRAP state exists.

Test Plan:
- MEM_HANDSHAKE=1, rst_n released, mem_ready low for 3 cycles then high, op=000000 → state 0 for 4 cycles; irwrite=pcwrite=1 only in the 4th; then states 1, 6 (aluop=10), 7 (regdst=1, regwrite=1); instr_done pulses in state 7; retired=1.
- lw (op=100011), single-cycle memory (MEM_HANDSHAKE=0, MEM_LAT=0) → states 0,1,2,3,4; MEMWB memtoreg=1, regwrite=1; 5 cycles total. With MEM_LAT=2 → 9 cycles total.
- sw (op=101011), MEM_HANDSHAKE=1, mem_ready low 2 cycles in MEMWR → memwrite=1 and iord=1 for 3 cycles; regwrite never asserted.
- beq (op=000100) with zero=1 → pcwrite=1, pcsrc=01 in state 8. Repeat with zero=0 → pcwrite=0.
- j (op=000010) → state 11: pcsrc=10, pcwrite=1. Then op=111111 → back to state 0 with a retired increment; with MC_ILLEGAL_TRAP_EN → state 12, illegal_op=1, no increment.
- rst_n pulsed low mid-MEMWR → memwrite=0 the same cycle; state=0, retired=0.
- CNT_W=4: 16 instructions retired → retired wraps to 0.
